rvm_gpr_port_ctrl: RTL

Operand-fetch and write-back sequencer that drives the read and write ports of the 32x32 GPR file on behalf of the multi-cycle control FSM. It accepts read requests (rs1/rs2 indices) and write-back requests (rd index plus data) over valid/ready handshakes. It sequences them onto the GPR file ports, registers the returned operands, and presents them to the execute stage. It sits between the decode/control logic and the GPR file, and owns all GPR port timing.

---
 rtl/rvm_gpr_port_ctrl_pkg.sv | 20 ++
 rtl/rvm_gpr_port_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rvm_gpr_port_ctrl_pkg.sv
// Shared types for the GPR port sequencer: FSM state encoding and the
// rule that decides whether a GPR port access is really performed.
package rvm_gpr_port_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {
    GPRC_IDLE  = 2'd0,
    GPRC_WRITE = 2'd1,
    GPRC_READ  = 2'd2,
    GPRC_OPND  = 2'd3
  } gprc_state_e;

  // x0 is hardwired to zero, so any access to index 0 is suppressed.
  function automatic logic port_active(input logic en, input logic [IDX_W-1:0] idx);
    return en && (idx != '0);
  endfunction

endpackage

// File: rtl/rvm_gpr_port_ctrl.sv
// Operand-fetch / write-back sequencer owning all GPR file port timing.
//   state | meaning
//   IDLE  | accept write-back (priority) or operand read request
//   WRITE | drive GPR write port from latched rd/data for one cycle
//   READ  | drive GPR read ports, capture operands at the edge
//   OPND  | hold operands valid until the consumer takes them
module rvm_gpr_port_ctrl
  import rvm_gpr_port_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic        clk_req,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rs1_en,
  input  logic        req_rs2_en,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,

  output logic        opnd_valid,
  input  logic        opnd_ready,
  output logic [31:0] opnd_rs1,
  output logic [31:0] opnd_rs2,

  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,

  output logic        rs1_en,
  output logic [4:0]  rs1_addr,
  input  logic [31:0] rs1_rdata,
  output logic        rs2_en,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs2_rdata,

  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata
);

  gprc_state_e      r_state;
  logic [IDX_W-1:0] r_wb_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic             r_rs1_en;
  logic             r_rs2_en;
  logic [IDX_W-1:0] r_rs1;
  logic [IDX_W-1:0] r_rs2;
  logic [XLEN-1:0]  r_opnd_rs1;
  logic [XLEN-1:0]  r_opnd_rs2;

  logic w_idle;
  logic w_in_write;
  logic w_in_read;
  logic w_in_opnd;
  logic w_rs1_act;
  logic w_rs2_act;

  assign w_idle     = (r_state == GPRC_IDLE);
  assign w_in_write = (r_state == GPRC_WRITE);
  assign w_in_read  = (r_state == GPRC_READ);
  assign w_in_opnd  = (r_state == GPRC_OPND);

  assign w_rs1_act  = w_in_read && port_active(r_rs1_en, r_rs1);
  assign w_rs2_act  = w_in_read && port_active(r_rs2_en, r_rs2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= GPRC_IDLE;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_rs1_en   <= 1'b0;
      r_rs2_en   <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_opnd_rs1 <= '0;
      r_opnd_rs2 <= '0;
    end else begin
      unique case (r_state)
        GPRC_IDLE: begin
          if (wb_valid) begin
            r_wb_rd   <= wb_rd;
            r_wb_data <= wb_data;
            r_state   <= GPRC_WRITE;
          end else if (req_valid) begin
            r_rs1_en  <= req_rs1_en;
            r_rs2_en  <= req_rs2_en;
            r_rs1     <= req_rs1;
            r_rs2     <= req_rs2;
            r_state   <= GPRC_READ;
          end
        end
        GPRC_WRITE: begin
          r_state <= GPRC_IDLE;
        end
        GPRC_READ: begin
          // Disabled or x0 ports yield zero rather than whatever the file drives.
          r_opnd_rs1 <= w_rs1_act ? rs1_rdata : '0;
          r_opnd_rs2 <= w_rs2_act ? rs2_rdata : '0;
          r_state    <= GPRC_OPND;
        end
        GPRC_OPND: begin
          if (opnd_ready) r_state <= GPRC_IDLE;
        end
        default: r_state <= GPRC_IDLE;
      endcase
    end
  end

  assign wb_ready   = w_idle;
  assign req_ready  = w_idle && !wb_valid;
  assign clk_req    = !w_idle || req_valid || wb_valid;

  assign rd_wen     = w_in_write && (r_wb_rd != '0);
  assign rd_addr    = w_in_write ? r_wb_rd   : '0;
  assign rd_wdata   = w_in_write ? r_wb_data : '0;

  assign rs1_en     = w_rs1_act;
  assign rs2_en     = w_rs2_act;
  assign rs1_addr   = w_in_read ? r_rs1 : '0;
  assign rs2_addr   = w_in_read ? r_rs2 : '0;

  assign opnd_valid = w_in_opnd;
  assign opnd_rs1   = r_opnd_rs1;
  assign opnd_rs2   = r_opnd_rs2;

endmodule
